// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the fetch stage: fixed-latency pipelined read,
// back-pressure, redirect flush, fault flagging and a program-load write port.
module instr_mem_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   input  logic                  flush,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_instr,
   output logic [31:0]           resp_addr,
   output logic                  resp_fault,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [31:0]           load_data
);

   localparam int          DEPTH = 1 << ADDR_WIDTH;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]         r_mem   [DEPTH];
   logic [LATENCY-1:0]  r_vld;
   logic [31:0]         r_addr  [LATENCY];
   logic [31:0]         r_instr [LATENCY];
   logic                r_fault [LATENCY];

   logic                  w_stall;
   logic                  w_accept;
   logic                  w_fault;
   logic [31:0]           w_off;
   logic [ADDR_WIDTH-1:0] w_index;
   logic [31:0]           w_rd_instr;

   // Handshakes are strict valid/ready: a transfer happens on a rising edge where
   // both are high; the response side holds all resp_* steady while valid && !ready.
   assign w_stall   = r_vld[LATENCY-1] && !resp_ready;
   assign req_ready = !load_en && !w_stall;
   assign w_accept  = req_valid && req_ready;

   assign w_off      = req_addr - BASE_ADDR;
   assign w_fault    = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                       (((w_off >> 2) >> ADDR_WIDTH) != 32'd0);
   assign w_index    = w_off[ADDR_WIDTH+1:2];
   assign w_rd_instr = w_fault ? NOP : r_mem[w_index];

   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_addr[i]  <= '0;
            r_instr[i] <= '0;
            r_fault[i] <= 1'b0;
         end
      end else begin
         if (!w_stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
               r_vld[i]   <= r_vld[i-1];
               r_addr[i]  <= r_addr[i-1];
               r_instr[i] <= r_instr[i-1];
               r_fault[i] <= r_fault[i-1];
            end
            r_vld[0] <= w_accept;
            if (w_accept) begin
               r_addr[0]  <= req_addr;
               r_instr[0] <= w_rd_instr;
               r_fault[0] <= w_fault;
            end
         end
         // A redirect empties every stage; only the fetch accepted on this edge survives.
         if (flush) begin
            r_vld <= LATENCY'(w_accept);
         end
      end
   end

   assign resp_valid = r_vld[LATENCY-1];
   assign resp_instr = r_instr[LATENCY-1];
   assign resp_addr  = r_addr[LATENCY-1];
   assign resp_fault = r_fault[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of pending responses.
module tb_instr_mem_responder;

  localparam int          AW      = 10;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          DEPTH   = 1 << AW;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_instr;
  logic [31:0]   resp_addr;
  logic          resp_fault;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  instr_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // reference model: pending responses {fault, addr, instr} plus the edge count
  // at which each one becomes visible; a stalled edge pushes every due time back.
  logic [31:0] ref_mem [DEPTH];
  logic [64:0] exp_q[$];
  int unsigned due_q[$];
  int unsigned cyc;
  logic        m_vld;
  logic        m_req_ready;
  logic [64:0] m_head;
  logic [31:0] words [4];

  function automatic logic ref_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (a < BASE) || ((off / 4) >= DEPTH);
  endfunction

  task automatic model_eval();
    m_vld       = (exp_q.size() > 0) && (due_q[0] <= cyc);
    m_head      = (exp_q.size() > 0) ? exp_q[0] : '0;
    m_req_ready = !load_en && !(m_vld && !resp_ready);
  endtask

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
  endtask

  // driver: apply one cycle of inputs (just after the falling edge)
  task automatic drive(input logic rv, input logic [31:0] a, input logic rr,
                       input logic fl, input logic le, input logic [AW-1:0] la,
                       input logic [31:0] ld);
    req_valid  = rv;
    req_addr   = a;
    resp_ready = rr;
    flush      = fl;
    load_en    = le;
    load_addr  = la;
    load_data  = ld;
    #1;
    model_eval();
  endtask

  // advance one rising edge and update the model with what that edge does
  task automatic step();
    logic        acc;
    logic        flt;
    logic [31:0] ins;
    logic [31:0] w;
    model_eval();
    acc = req_valid && m_req_ready;
    flt = ref_fault(req_addr);
    w   = (req_addr - BASE) / 4;
    ins = flt ? NOP : ref_mem[w[AW-1:0]];
    @(posedge clk);
    cyc++;
    if (m_vld && resp_ready) begin
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else if (m_vld) begin
      foreach (due_q[i]) due_q[i] = due_q[i] + 1;
    end
    if (flush) model_clear();
    if (load_en) ref_mem[load_addr] = load_data;
    if (acc) begin
      exp_q.push_back({flt, req_addr, ins});
      due_q.push_back(cyc + LATENCY - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, resp_valid, resp_fault, resp_addr, resp_instr} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b flt=%b addr=%h instr=%h, want rdy=1 vld=0 flt=0 addr=0 instr=0",
               req_ready, resp_valid, resp_fault, resp_addr, resp_instr);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1) * 4, 1, 0, 1,
            AW'(i), (i < 4) ? words[i] : $urandom);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL load_hs cyc=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 cyc, req_ready, resp_valid, m_req_ready, m_vld);
      end
      step();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_back_to_back();
    int nseen;
    nseen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 32'(i * 4), 1, 0, 0, 0, 0);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL b2b_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (resp_valid && nseen < 4) begin
        vectors++;
        if (i != nseen + 2 || resp_instr !== words[nseen] || resp_addr !== 32'(nseen * 4) || resp_fault !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_resp i=%0d: got instr=%h addr=%h flt=%b, want cycle %0d instr=%h addr=%h flt=0",
                   i, resp_instr, resp_addr, resp_fault, nseen + 2, words[nseen], nseen * 4);
        end
        nseen++;
      end
      step();
    end
    vectors++;
    if (nseen != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses, want 4", nseen);
    end
  endtask

  task automatic test_stall();
    int k;
    int ndone;
    k = 0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      drive(k < 8, 32'($urandom_range(0, DEPTH - 1) * 4), !(i >= 3 && i < 6), 0, 0, 0, 0);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL stall_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (m_vld) begin
        vectors++;
        if ({resp_fault, resp_addr, resp_instr} !== m_head) begin
          miscompares++;
          $display("FAIL stall_data i=%0d: got %h, want %h", i, {resp_fault, resp_addr, resp_instr}, m_head);
        end
      end
      if (i >= 3 && i < 6) begin
        vectors++;
        if (req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_ready i=%0d: got %b, want 0", i, req_ready);
        end
      end
      if (resp_valid && resp_ready) ndone++;
      if (k < 8 && m_req_ready) k++;
      step();
    end
    vectors++;
    if (ndone != 8) begin
      miscompares++;
      $display("FAIL stall_count: got %0d responses, want 8", ndone);
    end
  endtask

  task automatic test_fault();
    logic [31:0] fa [3];
    int nseen;
    fa[0] = 32'h0000_0006;
    fa[1] = 32'h0000_1000;
    fa[2] = 32'hFFFF_FFFC;
    nseen = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, (i < 3) ? fa[i] : 32'h0, 1, 0, 0, 0, 0);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL fault_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (resp_valid && nseen < 3) begin
        vectors++;
        if ({resp_fault, resp_addr, resp_instr} !== {1'b1, fa[nseen], NOP}) begin
          miscompares++;
          $display("FAIL fault_resp: got flt=%b addr=%h instr=%h, want flt=1 addr=%h instr=%h",
                   resp_fault, resp_addr, resp_instr, fa[nseen], NOP);
        end
        nseen++;
      end
      step();
    end
    vectors++;
    if (nseen != 3) begin
      miscompares++;
      $display("FAIL fault_count: got %0d responses, want 3", nseen);
    end
  endtask

  task automatic test_flush();
    int nafter;
    nafter = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 3, 32'(i * 4), 1, i == 2, 0, 0, 0);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL flush_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (i > 2 && resp_valid) begin
        vectors++;
        if ({resp_fault, resp_addr, resp_instr} !== {1'b0, 32'h8, 32'h3333_3333}) begin
          miscompares++;
          $display("FAIL flush_resp i=%0d: got addr=%h instr=%h flt=%b, want addr=8 instr=33333333 flt=0",
                   i, resp_addr, resp_instr, resp_fault);
        end
        nafter++;
      end
      step();
    end
    vectors++;
    if (nafter != 1) begin
      miscompares++;
      $display("FAIL flush_count: got %0d responses after flush, want 1", nafter);
    end
  endtask

  task automatic test_load_block();
    int nseen;
    nseen = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 2, 32'h4, 1, 0, i == 0, AW'(1), 32'hDEAD_BEEF);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL ldblk_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (i == 0) begin
        vectors++;
        if (req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ldblk_ready: got %b, want 0", req_ready);
        end
      end
      if (resp_valid) begin
        vectors++;
        if (resp_instr !== 32'hDEAD_BEEF || resp_addr !== 32'h4) begin
          miscompares++;
          $display("FAIL ldblk_resp: got addr=%h instr=%h, want addr=4 instr=deadbeef", resp_addr, resp_instr);
        end
        nseen++;
      end
      step();
    end
    vectors++;
    if (nseen != 1) begin
      miscompares++;
      $display("FAIL ldblk_count: got %0d responses, want 1", nseen);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    step();
    drive(1, 32'h4, 0, 0, 0, 0, 0);
    step();
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: got vld=%b, want 1", resp_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    vectors++;
    if ({resp_valid, resp_fault, resp_addr, resp_instr} !== 66'h0) begin
      miscompares++;
      $display("FAIL arst_drop: got vld=%b flt=%b addr=%h instr=%h, want all 0",
               resp_valid, resp_fault, resp_addr, resp_instr);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 32'h0, 1, 0, 0, 0, 0);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld} || (i == 0 && req_ready !== 1'b1)) begin
        miscompares++;
        $display("FAIL arst_after i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, AW'($urandom_range(0, DEPTH - 1)), $urandom);
      vectors++;
      if ({req_ready, resp_valid} !== {m_req_ready, m_vld}) begin
        miscompares++;
        $display("FAIL rand_hs i=%0d: got rdy=%b vld=%b, want rdy=%b vld=%b",
                 i, req_ready, resp_valid, m_req_ready, m_vld);
      end
      if (m_vld) begin
        vectors++;
        if ({resp_fault, resp_addr, resp_instr} !== m_head) begin
          miscompares++;
          $display("FAIL rand_data i=%0d: got %h, want %h", i, {resp_fault, resp_addr, resp_instr}, m_head);
        end
      end
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    words[0]    = 32'h1111_1111;
    words[1]    = 32'h2222_2222;
    words[2]    = 32'h3333_3333;
    words[3]    = 32'h4444_4444;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    resp_ready  = 1'b1;
    flush       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_fault();
    test_flush();
    test_load_block();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
